led_pattern_sequencer: RTL

- Autonomous sequencer that plays a programmable table of LED patterns onto the board LED PIO without CPU involvement per step.
- Configured by the Nios CPU through an Avalon-MM slave (s1).
- Drives the LED PIO's Avalon-MM slave through a simple zero-wait write master (m1).
- Sits between the system interconnect and the LED PIO in the SOPC system.

---
 rtl/led_pattern_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - plays a programmable LED pattern table onto an LED PIO
// Optional irq output enabled by defining LED_PATTERN_SEQUENCER_IRQ_EN.
module led_pattern_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
    output logic        irq,
`endif
    output logic [31:0] m_writedata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic                    run, loop_en, done;
    logic                    irq_en;
    logic [IW-1:0]           idx, idx_nxt;
    logic [PERIOD_WIDTH-1:0] period, cnt, cnt_nxt, eff_period;
    logic [4:0]              length, eff_len;
    logic [DATA_WIDTH-1:0]   pattern [DEPTH];
    logic                    wr, ctrl_wr, status_wr, busy, last_step;
    logic                    step, start, set_done, clr_run;
    logic                    unused_wdata;

    assign wr        = s_chipselect & ~s_write_n;
    assign ctrl_wr   = wr && (s_address == 4'd0);
    assign status_wr = wr && (s_address == 4'd1);
    assign busy      = (state == WRITE) || (state == WAIT);
    assign unused_wdata = ^s_writedata;

    assign eff_period = (period == '0) ? PERIOD_WIDTH'(1) : period;

    always_comb begin
        eff_len = length;
        if (length == 5'd0)
            eff_len = 5'd1;
        else if (length > 5'(DEPTH))
            eff_len = 5'(DEPTH);
    end

    assign last_step = 5'(idx) >= (eff_len - 5'd1);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        step      = 1'b0;
        start     = 1'b0;
        set_done  = 1'b0;
        clr_run   = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && s_writedata[0]) begin
                    start     = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (eff_period == PERIOD_WIDTH'(1)) begin
                    step = 1'b1;
                end else begin
                    cnt_nxt   = eff_period - PERIOD_WIDTH'(2);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0)
                    step = 1'b1;
                else
                    cnt_nxt = cnt - PERIOD_WIDTH'(1);
            end
            default: state_nxt = IDLE;
        endcase

        if (step) begin
            if (!last_step) begin
                idx_nxt   = idx + IW'(1);
                state_nxt = WRITE;
            end else if (loop_en) begin
                idx_nxt   = '0;
                state_nxt = WRITE;
            end else begin
                set_done  = 1'b1;
                clr_run   = 1'b1;
                state_nxt = DONE;
            end
        end

        // A RUN clear while busy aborts quietly: no DONE, index left where it was.
        if (busy && ctrl_wr && !s_writedata[0]) begin
            state_nxt = IDLE;
            idx_nxt   = idx;
            set_done  = 1'b0;
            clr_run   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            run     <= 1'b0;
            loop_en <= 1'b0;
            irq_en  <= 1'b0;
            done    <= 1'b0;
            period  <= PERIOD_WIDTH'(1);
            length  <= 5'(DEPTH);
            for (int i = 0; i < DEPTH; i++)
                pattern[i] <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            if (ctrl_wr) begin
                run     <= s_writedata[0];
                loop_en <= s_writedata[1];
`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
                irq_en  <= s_writedata[2];
`endif
            end
            if (clr_run)
                run <= 1'b0;
            if (wr && s_address == 4'd2)
                period <= s_writedata[PERIOD_WIDTH-1:0];
            if (wr && s_address == 4'd3)
                length <= s_writedata[4:0];
            for (int i = 0; i < DEPTH && i < 8; i++)
                if (wr && s_address == 4'(8 + i))
                    pattern[i] <= s_writedata[DATA_WIDTH-1:0];
            // Setting DONE outranks a simultaneous W1C.
            if (start)
                done <= 1'b0;
            else if (set_done)
                done <= 1'b1;
            else if (status_wr && s_writedata[1])
                done <= 1'b0;
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            4'd0: s_readdata[2:0] = {irq_en, loop_en, run};
            4'd1: begin
                s_readdata[0]    = busy;
                s_readdata[1]    = done;
                s_readdata[11:8] = 4'(idx);
            end
            4'd2: s_readdata[PERIOD_WIDTH-1:0] = period;
            4'd3: s_readdata[4:0] = length;
            default: begin
                for (int i = 0; i < DEPTH && i < 8; i++)
                    if (s_address == 4'(8 + i))
                        s_readdata[DATA_WIDTH-1:0] = pattern[i];
            end
        endcase
    end

    assign m_address    = 2'b00;
    assign m_chipselect = (state == WRITE);
    assign m_write_n    = ~(state == WRITE);
    assign m_writedata  = (state == WRITE) ? 32'(pattern[idx]) : 32'd0;

`ifdef LED_PATTERN_SEQUENCER_IRQ_EN
    assign irq = done & irq_en;
`endif
endmodule
